// File: rtl/ifetch.sv
// Instruction fetch stage: PC, req/ack memory port, 2-deep {pc,word} buffer.
// Optional misaligned-redirect fault under `IFETCH_ALIGN_CHECK_EN.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] pc0_q, pc0_d;
  logic [31:0] w0_q, w0_d;
  logic [31:0] pc1_q, pc1_d;
  logic [31:0] w1_q, w1_d;

  logic [31:0] tgt;
  logic        misal;
  logic        acked;
  logic        pop;
  logic        push;
  logic        start_ok;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign tgt   = redirect_pc;
  assign misal = |redirect_pc[1:0];
  assign fault = fault_q;
`else
  assign tgt   = redirect_pc & 32'hFFFF_FFFC;
  assign misal = 1'b0;
  assign fault = 1'b0;
`endif

  assign acked = req_q && imem_ack;
  assign pop   = (cnt_q != 2'd0) && instr_ready && !redirect;
  assign push  = (state_q == S_BUSY) && acked && !redirect;

  // Buffer: slot 0 is always the head, slot 1 shifts down on pop.
  always_comb begin
    pc0_d = pc0_q;
    w0_d  = w0_q;
    pc1_d = pc1_q;
    w1_d  = w1_q;
    if (pop) begin
      pc0_d = pc1_q;
      w0_d  = w1_q;
    end
    if (push) begin
      if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
        pc0_d = addr_q;
        w0_d  = imem_rdata;
      end else begin
        pc1_d = addr_q;
        w1_d  = imem_rdata;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (redirect) begin
      cnt_d = 2'd0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirect) begin
      pc_d    = tgt;
      fault_d = misal;
    end else if (push) begin
      pc_d = addr_q + 32'd4;
    end
  end

  // A new request counts as one occupied slot until it returns.
  assign start_ok = (cnt_d != 2'd2) && !fault_d;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          req_d   = 1'b1;
          addr_d  = pc_d;
          state_d = S_BUSY;
        end
      end
      S_BUSY, S_FLUSH: begin
        if (acked) begin
          req_d   = start_ok;
          state_d = start_ok ? S_BUSY : S_IDLE;
          if (start_ok) begin
            addr_d = pc_d;
          end
        end else if (redirect) begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      cnt_q   <= 2'd0;
      fault_q <= 1'b0;
      pc0_q   <= 32'd0;
      w0_q    <= 32'd0;
      pc1_q   <= 32'd0;
      w1_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      pc0_q   <= pc0_d;
      w0_q    <= w0_d;
      pc1_q   <= pc1_d;
      w1_q    <= w1_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (cnt_q != 2'd0);
  assign instr       = w0_q;
  assign instr_pc    = pc0_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: queue-based reference model checked every cycle,
// directed literal checks, then randomized memory/decoder/redirect traffic.
module tb_ifetch;

  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fault;

  ifetch #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = memword(imem_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: 0 zero-wait, 1 fixed 3-cycle latency, 2 random.
  int ack_mode = 0;
  int age = 0;
  always @(posedge clk) begin
    #1;
    if (!imem_req) age = 0;
    else if (imem_ack) age = 1;
    else age = age + 1;
    case (ack_mode)
      0: imem_ack = 1'b1;
      1: imem_ack = imem_req && (age >= 3);
      default: imem_ack = ($urandom_range(0, 99) < 55);
    endcase
  end

  // Reference model: delivered stream as a queue plus the one in-flight read.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        mq[$];
  bit          m_out;
  bit          m_disc;
  bit          m_fault;
  logic [31:0] m_addr;
  logic [31:0] m_next;
  bit          chk_en = 0;

  task automatic model_reset();
    mq.delete();
    m_out   = 0;
    m_disc  = 0;
    m_fault = 0;
    m_addr  = RPC;
    m_next  = RPC;
  endtask

  task automatic model_step();
    logic [31:0] t;
    bit mis;
    bit acked;
    ent_t e;
    acked = m_out && imem_ack;
    if (mq.size() != 0 && instr_ready && !redirect) void'(mq.pop_front());
    if (redirect) begin
      mq.delete();
`ifdef IFETCH_ALIGN_CHECK_EN
      t   = redirect_pc;
      mis = (t[1:0] != 2'b00);
`else
      t   = {redirect_pc[31:2], 2'b00};
      mis = 0;
`endif
      m_next  = t;
      m_fault = mis;
    end else if (acked && !m_disc) begin
      e.pc = m_addr;
      e.w  = memword(m_addr);
      mq.push_back(e);
      m_next = m_addr + 32'd4;
    end
    if (m_out && !acked) begin
      if (redirect) m_disc = 1;
    end else begin
      m_out  = 0;
      m_disc = 0;
      if (mq.size() < 2 && !m_fault) begin
        m_out  = 1;
        m_addr = m_next;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", imem_req, m_out);
      if (m_out) chk("addr", imem_addr, m_addr);
      chk("valid", instr_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("instr_pc", instr_pc, mq[0].pc);
        chk("instr", instr, mq[0].w);
      end
      chk("fault", fault, m_fault);
    end
    if (!reset_n) begin
      model_reset();
      chk_en = 1;
    end else if (chk_en) begin
      model_step();
    end
  end

  task automatic reset_dut();
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    redirect = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] a);
    @(posedge clk);
    #2;
    redirect    = 1'b1;
    redirect_pc = a;
    @(posedge clk);
    #2;
    redirect = 1'b0;
  endtask

  bit found;

  initial begin
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;

    // Zero-wait memory, decoder always ready.
    ack_mode = 0;
    reset_dut();
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fault", fault, 1'b0);
    @(negedge clk);
    chk("zw_req0", imem_req, 1'b1);
    chk("zw_addr0", imem_addr, 32'h0);
    chk("zw_valid0", instr_valid, 1'b0);
    @(negedge clk);
    chk("zw_addr1", imem_addr, 32'h4);
    chk("zw_valid1", instr_valid, 1'b1);
    chk("zw_pc1", instr_pc, 32'h0);
    @(negedge clk);
    chk("zw_addr2", imem_addr, 32'h8);
    chk("zw_pc2", instr_pc, 32'h4);
    repeat (20) @(negedge clk);

    // Decoder stalled: buffer fills, requests stop, resume in order.
    instr_ready = 1'b0;
    reset_dut();
    repeat (12) @(negedge clk);
    chk("stall_req", imem_req, 1'b0);
    chk("stall_valid", instr_valid, 1'b1);
    chk("stall_pc", instr_pc, 32'h0);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("resume_pc0", instr_pc, 32'h0);
    @(negedge clk);
    chk("resume_pc4", instr_pc, 32'h4);
    @(negedge clk);
    chk("resume_pc8", instr_pc, 32'h8);
    repeat (10) @(negedge clk);

    // Three-cycle memory latency.
    ack_mode    = 1;
    instr_ready = 1'b0;
    reset_dut();
    @(negedge clk);
    @(negedge clk);
    chk("lat_addr_c1", imem_addr, 32'h0);
    @(negedge clk);
    chk("lat_addr_c2", imem_addr, 32'h0);
    @(negedge clk);
    chk("lat_addr_c3", imem_addr, 32'h0);
    chk("lat_valid_c3", instr_valid, 1'b0);
    @(negedge clk);
    chk("lat_addr_c4", imem_addr, 32'h4);
    chk("lat_valid_c4", instr_valid, 1'b1);
    chk("lat_pc_c4", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (30) @(negedge clk);

    // Redirect while the read of 0x8 is still pending.
    reset_dut();
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (imem_req && imem_addr == 32'h8 && !imem_ack) begin
        found = 1;
        break;
      end
    end
    chk("pend8_seen", found, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(posedge clk);
    #2;
    redirect = 1'b0;
    @(negedge clk);
    chk("flush_valid", instr_valid, 1'b0);
    chk("flush_hold", imem_addr, 32'h8);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == 32'h100) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("flush_newreq", found, 1'b1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("flush_got", found, 1'b1);
    chk("flush_pc", instr_pc, 32'h100);
    repeat (10) @(negedge clk);

    // Redirect coinciding with an ack and a pop.
    ack_mode = 0;
    reset_dut();
    repeat (5) @(posedge clk);
    pulse_redirect(32'h300);
    @(negedge clk);
    chk("ra_valid", instr_valid, 1'b0);
    chk("ra_req", imem_req, 1'b1);
    chk("ra_addr", imem_addr, 32'h300);
    @(negedge clk);
    chk("ra_valid2", instr_valid, 1'b1);
    chk("ra_pc", instr_pc, 32'h300);
    repeat (5) @(negedge clk);

    // Misaligned redirect target.
    pulse_redirect(32'h102);
    @(negedge clk);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("mis_fault", fault, 1'b1);
    chk("mis_req", imem_req, 1'b0);
    chk("mis_valid", instr_valid, 1'b0);
    repeat (5) @(negedge clk);
    chk("mis_req_hold", imem_req, 1'b0);
    chk("mis_fault_hold", fault, 1'b1);
    pulse_redirect(32'h200);
    @(negedge clk);
    chk("al_fault", fault, 1'b0);
    chk("al_req", imem_req, 1'b1);
    chk("al_addr", imem_addr, 32'h200);
`else
    chk("mis_fault", fault, 1'b0);
    chk("mis_req", imem_req, 1'b1);
    chk("mis_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("mis_pc", instr_pc, 32'h100);
`endif
    repeat (5) @(negedge clk);

    // Randomized traffic.
    ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom();
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      reset_n     = ($urandom_range(0, 149) != 0);
    end
    @(posedge clk);
    #2;
    reset_n  = 1'b1;
    redirect = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
